// File: rtl/l2_arbiter_ctrl.sv
// Two-core L2 request arbiter/sequencer: grants one core, runs L2 lookup, dmem fetch + fill on load miss.
// Latency: store/load hit ack 2 cycles after grant edge, load miss 3+k; define L2_ARB_FIXED_PRIO_EN for fixed priority.
// Backpressure: requests are level-held until ack; non-granted core waits, dmem wait is unbounded.
module l2_arbiter_ctrl #(
   parameter logic [6:0] LOAD_OP  = 7'b0000011,
   parameter logic [6:0] STORE_OP = 7'b0100011
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [6:0]  opcode0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic [31:0] rdata0,
   input  logic        req1,
   input  logic [6:0]  opcode1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic [6:0]  l2_opcode,
   output logic [31:0] l2_bus_address,
   output logic [31:0] l2_bus_data,
   output logic [31:0] l2_data_from_dmem,
   input  logic [1:0]  l2_hit,
   input  logic [31:0] l2_rdata,
   output logic        dmem_rd_en,
   output logic [31:0] dmem_address,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_valid,
   output logic        busy,
   output logic        grant_id
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOOKUP  = 3'd1;
   localparam logic [2:0] DMEM_RD = 3'd2;
   localparam logic [2:0] FILL    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]  state;
   logic [6:0]  lat_op;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] cap_dat;
   logic        win;
   logic        is_load;
   logic        is_store;
   logic        fin_en;
   logic [31:0] fin_dat;

   assign is_load  = (lat_op == LOAD_OP);
   assign is_store = (lat_op == STORE_OP);

`ifdef L2_ARB_FIXED_PRIO_EN
   assign win = ~req0;
`else
   logic last_grant;
   assign win = (req0 & req1) ? ~last_grant : req1;
`endif

   // Data returned to the core is known either in LOOKUP (hit/store/other) or in FILL (miss)
   always_comb begin
      fin_en  = 1'b0;
      fin_dat = cap_dat;
      if (state == LOOKUP) begin
         if (!is_load) begin
            fin_en  = 1'b1;
            fin_dat = 32'h0;
         end else if (l2_hit == 2'b10) begin
            fin_en  = 1'b1;
            fin_dat = l2_rdata;
         end
      end else if (state == FILL) begin
         fin_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         grant_id  <= 1'b0;
         lat_op    <= 7'h0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         cap_dat   <= 32'h0;
         rdata0    <= 32'h0;
         rdata1    <= 32'h0;
`ifndef L2_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         if (fin_en) begin
            cap_dat <= fin_dat;
            if (grant_id) rdata1 <= fin_dat;
            else          rdata0 <= fin_dat;
         end
         case (state)
            IDLE: if (req0 | req1) begin
               grant_id  <= win;
`ifndef L2_ARB_FIXED_PRIO_EN
               last_grant <= win;
`endif
               lat_op    <= win ? opcode1 : opcode0;
               lat_addr  <= win ? addr1   : addr0;
               lat_wdata <= win ? wdata1  : wdata0;
               state     <= LOOKUP;
            end
            LOOKUP:  state <= (is_load && l2_hit != 2'b10) ? DMEM_RD : DONE;
            DMEM_RD: if (dmem_valid) begin
               cap_dat <= dmem_rdata;
               state   <= FILL;
            end
            FILL:    state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // All outputs below decode only from state and registers
   always_comb begin
      l2_opcode         = 7'h0;
      l2_bus_address    = 32'h0;
      l2_bus_data       = 32'h0;
      l2_data_from_dmem = 32'h0;
      dmem_rd_en        = 1'b0;
      dmem_address      = 32'h0;
      case (state)
         LOOKUP: begin
            l2_opcode      = (is_load | is_store) ? lat_op : 7'h0;
            l2_bus_address = lat_addr;
            l2_bus_data    = lat_wdata;
         end
         DMEM_RD: begin
            dmem_rd_en   = 1'b1;
            dmem_address = lat_addr;
         end
         FILL: begin
            l2_opcode         = LOAD_OP;
            l2_bus_address    = lat_addr;
            l2_data_from_dmem = cap_dat;
         end
         default: ;
      endcase
   end

   assign ack0 = (state == DONE) && !grant_id;
   assign ack1 = (state == DONE) &&  grant_id;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_l2_arbiter_ctrl.sv
// Directed bench for l2_arbiter_ctrl: store, load hit, load miss, arbitration, reset abort, unknown opcode.
module tb_l2_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [6:0]  opcode0, opcode1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic [6:0]  l2_opcode;
   logic [31:0] l2_bus_address, l2_bus_data, l2_data_from_dmem;
   logic [1:0]  l2_hit;
   logic [31:0] l2_rdata;
   logic        dmem_rd_en;
   logic [31:0] dmem_address, dmem_rdata;
   logic        dmem_valid;
   logic        busy, grant_id;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   always #5 clk = ~clk;

   l2_arbiter_ctrl dut (
      .clk(clk), .reset(reset),
      .req0(req0), .opcode0(opcode0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .opcode1(opcode1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .l2_opcode(l2_opcode), .l2_bus_address(l2_bus_address), .l2_bus_data(l2_bus_data),
      .l2_data_from_dmem(l2_data_from_dmem), .l2_hit(l2_hit), .l2_rdata(l2_rdata),
      .dmem_rd_en(dmem_rd_en), .dmem_address(dmem_address), .dmem_rdata(dmem_rdata),
      .dmem_valid(dmem_valid), .busy(busy), .grant_id(grant_id)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_g;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      opcode0 = 7'h0; opcode1 = 7'h0;
      addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
      l2_hit = 2'b00; l2_rdata = 32'h0; dmem_rdata = 32'h0; dmem_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_l2_opcode", {25'h0, l2_opcode}, 32'h0);
      chk("rst_dmem_rd_en", {31'h0, dmem_rd_en}, 32'h0);
      chk("rst_acks", {30'h0, ack1, ack0}, 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_grant_id", {31'h0, grant_id}, 32'h0);

      // store from core 0
      req0 = 1'b1; opcode0 = ST; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
      tick();
      chk("st_lookup_op", {25'h0, l2_opcode}, {25'h0, ST});
      chk("st_lookup_addr", l2_bus_address, 32'h10);
      chk("st_lookup_data", l2_bus_data, 32'hDEAD_BEEF);
      chk("st_lookup_ack", {30'h0, ack1, ack0}, 32'h0);
      tick();
      chk("st_done_ack", {30'h0, ack1, ack0}, 32'h1);
      chk("st_done_op", {25'h0, l2_opcode}, 32'h0);
      req0 = 1'b0;
      tick();
      chk("st_idle_busy", {31'h0, busy}, 32'h0);
      chk("st_idle_ack", {31'h0, ack0}, 32'h0);

      // load hit from core 0
      req0 = 1'b1; opcode0 = LD; addr0 = 32'h10; l2_hit = 2'b10; l2_rdata = 32'hDEAD_BEEF;
      tick();
      chk("hit_lookup_op", {25'h0, l2_opcode}, {25'h0, LD});
      chk("hit_lookup_dmem", {31'h0, dmem_rd_en}, 32'h0);
      tick();
      chk("hit_done_ack", {30'h0, ack1, ack0}, 32'h1);
      chk("hit_done_rdata0", rdata0, 32'hDEAD_BEEF);
      chk("hit_done_dmem", {31'h0, dmem_rd_en}, 32'h0);
      req0 = 1'b0; l2_hit = 2'b00; l2_rdata = 32'h0;
      tick();

      // load miss from core 1, dmem answers in the third DMEM_RD cycle
      req1 = 1'b1; opcode1 = LD; addr1 = 32'h400; l2_hit = 2'b01;
      tick();
      chk("miss_grant", {31'h0, grant_id}, 32'h1);
      tick();
      l2_hit = 2'b00;
      chk("miss_dmem_en", {31'h0, dmem_rd_en}, 32'h1);
      chk("miss_dmem_addr", dmem_address, 32'h400);
      chk("miss_dmem_op", {25'h0, l2_opcode}, 32'h0);
      tick();
      chk("miss_dmem_en2", {31'h0, dmem_rd_en}, 32'h1);
      tick();
      dmem_valid = 1'b1; dmem_rdata = 32'h1234_5678;
      tick();
      dmem_valid = 1'b0; dmem_rdata = 32'h0;
      chk("fill_op", {25'h0, l2_opcode}, {25'h0, LD});
      chk("fill_data", l2_data_from_dmem, 32'h1234_5678);
      chk("fill_addr", l2_bus_address, 32'h400);
      chk("fill_dmem_en", {31'h0, dmem_rd_en}, 32'h0);
      chk("fill_ack", {30'h0, ack1, ack0}, 32'h0);
      tick();
      chk("miss_done_ack", {30'h0, ack1, ack0}, 32'h2);
      chk("miss_done_rdata1", rdata1, 32'h1234_5678);
      chk("rdata0_hold", rdata0, 32'hDEAD_BEEF);
      req1 = 1'b0;
      tick();

      // both cores request stores for four back-to-back transactions
      req0 = 1'b1; req1 = 1'b1; opcode0 = ST; opcode1 = ST;
      addr0 = 32'h100; addr1 = 32'h200; wdata0 = 32'hA; wdata1 = 32'hB;
      for (int i = 0; i < 4; i++) begin
`ifdef L2_ARB_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = i[0];
`endif
         tick();
         chk($sformatf("arb_grant_%0d", i), {31'h0, grant_id}, {31'h0, exp_g});
         chk($sformatf("arb_addr_%0d", i), l2_bus_address, exp_g ? 32'h200 : 32'h100);
         tick();
         chk($sformatf("arb_ack_%0d", i), {30'h0, ack1, ack0}, exp_g ? 32'h2 : 32'h1);
         if (i == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         tick();
      end

      // reset while waiting on dmem, request held throughout
      req0 = 1'b1; opcode0 = LD; addr0 = 32'h80; l2_hit = 2'b01;
      tick();
      tick();
      chk("abort_dmem_en", {31'h0, dmem_rd_en}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_dmem_off", {31'h0, dmem_rd_en}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_ack", {30'h0, ack1, ack0}, 32'h0);
      chk("abort_rdata0", rdata0, 32'h0);
      l2_hit = 2'b10; l2_rdata = 32'hCAFE_F00D;
      tick();
      chk("rearb_busy", {31'h0, busy}, 32'h1);
      chk("rearb_op", {25'h0, l2_opcode}, {25'h0, LD});
      chk("rearb_addr", l2_bus_address, 32'h80);
      tick();
      chk("rearb_ack", {30'h0, ack1, ack0}, 32'h1);
      chk("rearb_rdata0", rdata0, 32'hCAFE_F00D);
      req0 = 1'b0; l2_hit = 2'b00;
      tick();

      // unsupported opcode
      req0 = 1'b1; opcode0 = 7'b0110011; addr0 = 32'h20;
      tick();
      chk("other_busy", {31'h0, busy}, 32'h1);
      chk("other_op_lookup", {25'h0, l2_opcode}, 32'h0);
      tick();
      chk("other_ack", {30'h0, ack1, ack0}, 32'h1);
      chk("other_rdata0", rdata0, 32'h0);
      chk("other_op_done", {25'h0, l2_opcode}, 32'h0);
      req0 = 1'b0;
      tick();
      chk("other_idle_ack", {31'h0, ack0}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/l2_arbiter_ctrl.md
# l2_arbiter_ctrl

Two-core request arbiter and sequencer for the shared L2 cache subsystem. It sits between the two cores' L1/LSU miss ports and the single L2 port. It grants one core at a time and drives the L2 opcode/address/data bus. On an L2 load miss it fetches the word from data memory, replays the load so L2 installs the line, then returns the data and an acknowledge to the granted core.

## Interface
- Parameters:
- `LOAD_OP`, 7'b0000011: opcode treated as load.
- `STORE_OP`, 7'b0100011: opcode treated as store.
- Ports (N = 0, 1 for per-core ports):
- `clk` input 1: single clock. All state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `reqN` input 1: core N request, level. Held with stable fields until `ackN`.
- `opcodeN` input 7: core N opcode.
- `addrN` input 32: core N byte address.
- `wdataN` input 32: core N store data.
- `ackN` output 1: one-cycle completion pulse to core N.
- `rdataN` output 32: load data to core N. Valid while `ackN`=1.
- `l2_opcode` output 7: opcode to L2. 7'b0 when idle.
- `l2_bus_address` output 32: address to L2.
- `l2_bus_data` output 32: store data to L2.
- `l2_data_from_dmem` output 32: fill data to L2.
- `l2_hit` input 2: L2 lookup result, 2'b10 = hit, 2'b01 = miss.
- `l2_rdata` input 32: L2 load hit data.
- `dmem_rd_en` output 1: data memory read request. Held until `dmem_valid`.
- `dmem_address` output 32: data memory read address.
- `dmem_rdata` input 32: data memory read data.
- `dmem_valid` input 1: `dmem_rdata` valid this cycle.
- `busy` output 1: FSM not in IDLE.
- `grant_id` output 1: currently or last granted core.

## Operation
- FSM states: IDLE, LOOKUP, DMEM_RD, FILL, DONE.
- IDLE:
  - If any `reqN` is high, select a winner and latch its opcode, address and wdata into internal registers.
  - Set `grant_id` and go to LOOKUP.
  - Requester fields are not sampled again during the transaction.
- Arbitration: round-robin.
  - With only one request, grant it.
  - With both requests, grant the core other than `last_grant`.
  - `last_grant` updates at each grant and resets to 1, so core 0 wins the first tie.
- LOOKUP:
  - Drive `l2_opcode`, `l2_bus_address` and `l2_bus_data` from the latched registers for the full cycle.
  - Store: go to DONE. L2 performs the write within this cycle.
  - Load with `l2_hit`=2'b10: capture `l2_rdata`, go to DONE.
  - Load with `l2_hit`=2'b01: go to DMEM_RD.
  - Opcode neither load nor store: `l2_opcode` stays 0, captured data is 0, go to DONE.
- DMEM_RD:
  - `dmem_rd_en`=1 and `dmem_address` = latched address. `l2_opcode`=0.
  - On `dmem_valid`: capture `dmem_rdata` and go to FILL.
  - No timeout. Wait indefinitely.
- FILL:
  - Drive `l2_opcode`=LOAD_OP, the latched address, and `l2_data_from_dmem` = captured word for exactly one cycle, so L2 takes its miss-fill path.
  - Go to DONE.
- DONE:
  - `ack[grant_id]`=1 for one cycle; `rdata[grant_id]` = captured data. The other `ack` is 0.
  - Go to IDLE.
- Requester contract: deassert `reqN` the cycle after `ackN`. A request still high in IDLE is treated as a new transaction.
- `rdataN` holds its last value between acks.

## Timing
- Reset values: all outputs 0.
  - Includes `l2_opcode`=7'b0, `dmem_rd_en`=0, `ackN`=0, `rdataN`=0, `busy`=0, `grant_id`=0.
  - Internal state: FSM=IDLE, `last_grant`=1, latched registers 0.
- Store or load hit: request seen in IDLE at edge T, LOOKUP in cycle T+1, `ack` in cycle T+2. Latency 2 cycles, next grant earliest T+3.
- Load miss: IDLE, then LOOKUP, then DMEM_RD (k ≥ 1 cycles; `dmem_valid` may arrive in the first DMEM_RD cycle), then FILL, then DONE. `ack` at T+3+k.
- All outputs are registered or decoded from the state register only. No combinational path from `reqN`, `l2_hit` or `dmem_valid` to any output.
- Non-granted request during a transaction: ignored; it waits for the next IDLE.
- `reset` mid-transaction: return to IDLE the next cycle with reset values.
  - `dmem_rd_en` drops and no `ack` is issued.
  - The aborted request is re-arbitrated if still held.

## Configuration
- `L2_ARB_FIXED_PRIO_EN` defined: fixed priority. Core 0 always wins when both request; `last_grant` is unused.
- Not defined: round-robin as specified above.

## Test plan
- Reset, then req0 store (opcode 0100011, addr 0x0000_0010, wdata 0xDEAD_BEEF) → LOOKUP drives those values, `ack0` 2 cycles later, `l2_opcode` back to 0.
- req0 load to 0x10 with `l2_hit`=2'b10, `l2_rdata`=0xDEAD_BEEF → `ack0` at +2 with `rdata0`=0xDEAD_BEEF, `dmem_rd_en` never asserted.
- req1 load to 0x400 with `l2_hit`=2'b01, `dmem_valid` after 3 cycles with 0x1234_5678 → one FILL cycle with `l2_opcode`=0000011 and `l2_data_from_dmem`=0x1234_5678, then `ack1` with `rdata1`=0x1234_5678 at +6.
- req0 and req1 asserted together for 4 transactions → grant order 0,1,0,1. With `L2_ARB_FIXED_PRIO_EN`, core 0 is granted whenever both are pending.
- `reset` asserted during DMEM_RD → next cycle IDLE, `dmem_rd_en`=0, no `ack`. A held request is then re-served from LOOKUP.
- req0 with opcode 0110011 → `ack0` at +2, `rdata0`=0, `l2_opcode` remains 0 throughout.
